or1k_rf_operand_fetch: RTL and testbench

OR1K_RF_OPERAND_FETCH -- requirements
Module: or1k_rf_operand_fetch

---
 rtl/or1k_rf_pkg.sv | 23 ++
 rtl/or1k_rf_scoreboard.sv | 55 +++++
 rtl/or1k_rf_operand_fetch.sv | 118 +++++++++++
 tb/tb_or1k_rf_operand_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or1k_rf_pkg
// Description : Shared register-file constants, address type and the helper
//               that derives the register count from the address width.
// Revision    : 1.0 - initial release
// ============================================================================
package or1k_rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_REGS   = 1 << RF_ADDR_WIDTH;

  // r0 is hardwired to zero: never written, never pending, always reads 0
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ZERO_REG = '0;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_adr_t;

  function automatic int rf_num_regs(input int adr_width);
    return 1 << adr_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/or1k_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : or1k_rf_scoreboard
// Description : Pending-write vector for in-flight destinations plus the
//               combinational hazard lookup for both source ports.
// Revision    : 1.0 - initial release
// ============================================================================
module or1k_rf_scoreboard
  import or1k_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_adr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_adr,
  input  logic [ADDR_WIDTH-1:0] rda_adr,
  input  logic [ADDR_WIDTH-1:0] rdb_adr,
  output logic                  hazard_a,
  output logic                  hazard_b
);

  localparam int NUM_REGS = rf_num_regs(ADDR_WIDTH);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Clear first so a same-register set wins; flush wipes everything last
  always_comb begin
    pending_next = pending;
    if (clr_en)
      pending_next[clr_adr] = 1'b0;
    if (set_en && (set_adr != '0))
      pending_next[set_adr] = 1'b1;
    if (flush)
      pending_next = '0;
  end

  // Pending vector register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending <= '0;
    else
      pending <= pending_next;
  end

  // Lookup uses pre-update state; a writeback landing this cycle resolves it
  assign hazard_a = pending[rda_adr] & ~(clr_en && (clr_adr == rda_adr)) & (rda_adr != '0);
  assign hazard_b = pending[rdb_adr] & ~(clr_en && (clr_adr == rdb_adr)) & (rdb_adr != '0);

endmodule
`default_nettype wire

// File: rtl/or1k_rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : or1k_rf_operand_fetch
// Description : Register file with writeback bypass, registered operand
//               outputs and per-operand hazard flags from the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module or1k_rf_operand_fetch
  import or1k_rf_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            pipeline_flush_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
  input  logic                            dec_rfd_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dec_rfd_adr_i,
  input  logic                            wb_rf_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
  output logic                            hazard_a_o,
  output logic                            hazard_b_o
);

  localparam int NUM_REGS = rf_num_regs(OPTION_RF_ADDR_WIDTH);

  logic [OPTION_OPERAND_WIDTH-1:0] mem [NUM_REGS];
  logic [OPTION_OPERAND_WIDTH-1:0] fetch_a;
  logic [OPTION_OPERAND_WIDTH-1:0] fetch_b;
  logic [OPTION_RF_ADDR_WIDTH-1:0] cap_adr_a;
  logic [OPTION_RF_ADDR_WIDTH-1:0] cap_adr_b;
  logic                            lookup_a;
  logic                            lookup_b;
  logic                            wb_hit_cap_a;
  logic                            wb_hit_cap_b;

  // Storage array: plain write port, no reset, so it maps onto RAM
  always_ff @(posedge clk) begin
    if (wb_rf_we_i && (wb_rfd_adr_i != '0))
      mem[wb_rfd_adr_i] <= wb_result_i;
  end

  // Read mux: r0 forced to zero, same-cycle writeback bypasses the array
  always_comb begin
    fetch_a = mem[rfa_adr_i];
    fetch_b = mem[rfb_adr_i];
    if (wb_rf_we_i && (wb_rfd_adr_i == rfa_adr_i))
      fetch_a = wb_result_i;
    if (wb_rf_we_i && (wb_rfd_adr_i == rfb_adr_i))
      fetch_b = wb_result_i;
    if (rfa_adr_i == '0)
      fetch_a = '0;
    if (rfb_adr_i == '0)
      fetch_b = '0;
  end

  assign wb_hit_cap_a = wb_rf_we_i && (wb_rfd_adr_i == cap_adr_a) && (cap_adr_a != '0);
  assign wb_hit_cap_b = wb_rf_we_i && (wb_rfd_adr_i == cap_adr_b) && (cap_adr_b != '0);

  or1k_rf_scoreboard #(
    .ADDR_WIDTH (OPTION_RF_ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (pipeline_flush_i),
    .set_en   (padv_decode_i & dec_rfd_we_i),
    .set_adr  (dec_rfd_adr_i),
    .clr_en   (wb_rf_we_i),
    .clr_adr  (wb_rfd_adr_i),
    .rda_adr  (rfa_adr_i),
    .rdb_adr  (rfb_adr_i),
    .hazard_a (lookup_a),
    .hazard_b (lookup_b)
  );

  // Operand capture on decode advance; while holding, a matching writeback
  // refreshes the operand and resolves its hazard; flush clears both hazards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rfa_o      <= '0;
      rfb_o      <= '0;
      hazard_a_o <= 1'b0;
      hazard_b_o <= 1'b0;
      cap_adr_a  <= '0;
      cap_adr_b  <= '0;
    end else begin
      if (padv_decode_i) begin
        rfa_o      <= fetch_a;
        rfb_o      <= fetch_b;
        hazard_a_o <= lookup_a;
        hazard_b_o <= lookup_b;
        cap_adr_a  <= rfa_adr_i;
        cap_adr_b  <= rfb_adr_i;
      end else begin
        if (wb_hit_cap_a) begin
          rfa_o      <= wb_result_i;
          hazard_a_o <= 1'b0;
        end
        if (wb_hit_cap_b) begin
          rfb_o      <= wb_result_i;
          hazard_b_o <= 1'b0;
        end
      end
      if (pipeline_flush_i) begin
        hazard_a_o <= 1'b0;
        hazard_b_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_or1k_rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_or1k_rf_operand_fetch
// Description : Directed self-checking bench for the operand fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or1k_rf_operand_fetch;

  logic        clk;
  logic        rst;
  logic        padv_decode_i;
  logic        pipeline_flush_i;
  logic [4:0]  rfa_adr_i;
  logic [4:0]  rfb_adr_i;
  logic        dec_rfd_we_i;
  logic [4:0]  dec_rfd_adr_i;
  logic        wb_rf_we_i;
  logic [4:0]  wb_rfd_adr_i;
  logic [31:0] wb_result_i;
  logic [31:0] rfa_o;
  logic [31:0] rfb_o;
  logic        hazard_a_o;
  logic        hazard_b_o;

  int checks;
  int errors;

  or1k_rf_operand_fetch #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .padv_decode_i    (padv_decode_i),
    .pipeline_flush_i (pipeline_flush_i),
    .rfa_adr_i        (rfa_adr_i),
    .rfb_adr_i        (rfb_adr_i),
    .dec_rfd_we_i     (dec_rfd_we_i),
    .dec_rfd_adr_i    (dec_rfd_adr_i),
    .wb_rf_we_i       (wb_rf_we_i),
    .wb_rfd_adr_i     (wb_rfd_adr_i),
    .wb_result_i      (wb_result_i),
    .rfa_o            (rfa_o),
    .rfb_o            (rfb_o),
    .hazard_a_o       (hazard_a_o),
    .hazard_b_o       (hazard_b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    padv_decode_i    = 1'b0;
    pipeline_flush_i = 1'b0;
    rfa_adr_i        = 5'd0;
    rfb_adr_i        = 5'd0;
    dec_rfd_we_i     = 1'b0;
    dec_rfd_adr_i    = 5'd0;
    wb_rf_we_i       = 1'b0;
    wb_rfd_adr_i     = 5'd0;
    wb_result_i      = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    step();
    step();
    checks++; if (rfa_o !== 32'd0) begin errors++; $display("FAIL reset_rfa got %h want %h", rfa_o, 32'd0); end
    checks++; if (rfb_o !== 32'd0) begin errors++; $display("FAIL reset_rfb got %h want %h", rfb_o, 32'd0); end
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL reset_haz_a got %b want 0", hazard_a_o); end
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL reset_haz_b got %b want 0", hazard_b_o); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_read();
    idle();
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd3; wb_result_i = 32'h0000_1234;
    step();
    idle();
    step();
    padv_decode_i = 1'b1; rfa_adr_i = 5'd3; rfb_adr_i = 5'd0;
    step();
    idle();
    checks++; if (rfa_o !== 32'h0000_1234) begin errors++; $display("FAIL basic_rfa got %h want %h", rfa_o, 32'h0000_1234); end
    checks++; if (rfb_o !== 32'd0) begin errors++; $display("FAIL basic_rfb_r0 got %h want %h", rfb_o, 32'd0); end
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL basic_haz_a got %b want 0", hazard_a_o); end
    step();
    checks++; if (rfa_o !== 32'h0000_1234) begin errors++; $display("FAIL basic_hold got %h want %h", rfa_o, 32'h0000_1234); end
  endtask

  task automatic test_bypass();
    idle();
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd5; wb_result_i = 32'hDEAD_BEEF;
    padv_decode_i = 1'b1; rfa_adr_i = 5'd5; rfb_adr_i = 5'd5;
    step();
    idle();
    checks++; if (rfa_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rfa got %h want %h", rfa_o, 32'hDEAD_BEEF); end
    checks++; if (rfb_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rfb got %h want %h", rfb_o, 32'hDEAD_BEEF); end
    // Same-cycle writeback to a pending register hides the hazard
    padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd12;
    step();
    idle();
    padv_decode_i = 1'b1; rfa_adr_i = 5'd12; rfb_adr_i = 5'd3;
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd12; wb_result_i = 32'h0000_00C3;
    step();
    idle();
    checks++; if (rfa_o !== 32'h0000_00C3) begin errors++; $display("FAIL bypass_pend_rfa got %h want %h", rfa_o, 32'h0000_00C3); end
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL bypass_pend_haz_a got %b want 0", hazard_a_o); end
    checks++; if (rfb_o !== 32'h0000_1234) begin errors++; $display("FAIL bypass_other_rfb got %h want %h", rfb_o, 32'h0000_1234); end
  endtask

  task automatic test_zero_reg();
    idle();
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd0; wb_result_i = 32'hFFFF_FFFF;
    padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd0;
    step();
    idle();
    padv_decode_i = 1'b1; rfa_adr_i = 5'd0; rfb_adr_i = 5'd0;
    step();
    idle();
    checks++; if (rfa_o !== 32'd0) begin errors++; $display("FAIL zero_rfa got %h want %h", rfa_o, 32'd0); end
    checks++; if (rfb_o !== 32'd0) begin errors++; $display("FAIL zero_rfb got %h want %h", rfb_o, 32'd0); end
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL zero_haz_a got %b want 0", hazard_a_o); end
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL zero_haz_b got %b want 0", hazard_b_o); end
  endtask

  task automatic test_hazard_hold();
    idle();
    padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd7;
    step();
    idle();
    padv_decode_i = 1'b1; rfa_adr_i = 5'd7; rfb_adr_i = 5'd5;
    step();
    idle();
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL hazard_set_a got %b want 1", hazard_a_o); end
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL hazard_clean_b got %b want 0", hazard_b_o); end
    step();
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL hazard_held_a got %b want 1", hazard_a_o); end
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd7; wb_result_i = 32'h0000_0055;
    step();
    idle();
    checks++; if (rfa_o !== 32'h0000_0055) begin errors++; $display("FAIL hazard_wb_rfa got %h want %h", rfa_o, 32'h0000_0055); end
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL hazard_wb_haz_a got %b want 0", hazard_a_o); end
    checks++; if (rfb_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hazard_rfb_kept got %h want %h", rfb_o, 32'hDEAD_BEEF); end
    padv_decode_i = 1'b1; rfa_adr_i = 5'd7;
    step();
    idle();
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL hazard_cleared_a got %b want 0", hazard_a_o); end
    checks++; if (rfa_o !== 32'h0000_0055) begin errors++; $display("FAIL hazard_reread_rfa got %h want %h", rfa_o, 32'h0000_0055); end
  endtask

  task automatic test_set_priority();
    idle();
    padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd10;
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd10; wb_result_i = 32'h0000_0001;
    step();
    idle();
    padv_decode_i = 1'b1; rfb_adr_i = 5'd10;
    step();
    idle();
    checks++; if (hazard_b_o !== 1'b1) begin errors++; $display("FAIL prio_haz_b got %b want 1", hazard_b_o); end
    checks++; if (rfb_o !== 32'h0000_0001) begin errors++; $display("FAIL prio_rfb got %h want %h", rfb_o, 32'h0000_0001); end
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd10; wb_result_i = 32'h0000_0002;
    step();
    idle();
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL prio_clr_haz_b got %b want 0", hazard_b_o); end
  endtask

  task automatic test_flush();
    idle();
    padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd9;
    step();
    idle();
    // Hold a hazarded operand, then flush while re-setting r9
    padv_decode_i = 1'b1; rfa_adr_i = 5'd9;
    step();
    idle();
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL flush_pre_haz_a got %b want 1", hazard_a_o); end
    pipeline_flush_i = 1'b1; padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd9;
    rfa_adr_i = 5'd9;
    step();
    idle();
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL flush_haz_a got %b want 0", hazard_a_o); end
    padv_decode_i = 1'b1; rfa_adr_i = 5'd9; rfb_adr_i = 5'd9;
    step();
    idle();
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL flush_read_haz_a got %b want 0", hazard_a_o); end
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL flush_read_haz_b got %b want 0", hazard_b_o); end
  endtask

  task automatic test_async_reset();
    idle();
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd11; wb_result_i = 32'h0000_0077;
    step();
    idle();
    padv_decode_i = 1'b1; dec_rfd_we_i = 1'b1; dec_rfd_adr_i = 5'd11;
    step();
    idle();
    padv_decode_i = 1'b1; rfb_adr_i = 5'd11;
    step();
    idle();
    checks++; if (hazard_b_o !== 1'b1) begin errors++; $display("FAIL areset_pre_haz_b got %b want 1", hazard_b_o); end
    checks++; if (rfb_o !== 32'h0000_0077) begin errors++; $display("FAIL areset_pre_rfb got %h want %h", rfb_o, 32'h0000_0077); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL areset_haz_b got %b want 0", hazard_b_o); end
    checks++; if (rfb_o !== 32'd0) begin errors++; $display("FAIL areset_rfb got %h want %h", rfb_o, 32'd0); end
    step();
    rst = 1'b1;
    step();
    padv_decode_i = 1'b1; rfb_adr_i = 5'd11;
    step();
    idle();
    checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL areset_pend_cleared got %b want 0", hazard_b_o); end
    checks++; if (rfb_o !== 32'h0000_0077) begin errors++; $display("FAIL areset_array_kept got %h want %h", rfb_o, 32'h0000_0077); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_read();
    test_bypass();
    test_zero_reg();
    test_hazard_hold();
    test_set_priority();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
